// File: rtl/trace_tx.sv
// Debug trace transmitter: captures {readDataMem, ALUa, ALUb} into a FIFO and
// streams each sample as a 13-byte frame (SYNC + 12 data bytes) on valid/ready.
module trace_tx #(
  parameter int          DEPTH = 8,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_en,
  input  logic [31:0]              readDataMem,
  input  logic [31:0]              ALUa,
  input  logic [31:0]              ALUb,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int         AW       = $clog2(DEPTH);
  localparam int         CW       = AW + 1;
  localparam logic [3:0] LAST_IDX = 4'd12;

  typedef enum logic {IDLE, SEND} state_e;

  logic [95:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;

  logic          full, xfer, pop, push;
  logic [95:0]   head;

  // Byte k (1..12) of a sample, MSB-first across the 96-bit word.
  function automatic logic [7:0] frame_byte(input logic [95:0] s, input logic [3:0] k);
    int sh;
    sh = 8 * (12 - int'(k));
    return 8'(s >> sh);
  endfunction

  assign full = (count_q == CW'(DEPTH));
  assign xfer = tx_valid_q & tx_ready;
  assign pop  = (state_q == SEND) & xfer & (idx_q == LAST_IDX);
  // A full FIFO still accepts a sample on the edge its head is popped.
  assign push = cap_en & (~full | pop);
  assign head = mem_q[rd_ptr_q];

  assign count_d = count_q + CW'(push) - CW'(pop);

  // NOTE: sample storage has no reset; occupancy is tracked by the pointers
  // and count, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {readDataMem, ALUa, ALUb};
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      if (cap_en && full && !pop) overflow_q <= 1'b1;
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      IDLE: begin
        tx_valid_d = 1'b0;
        if (count_q != '0) begin
          state_d    = SEND;
          idx_d      = '0;
          tx_data_d  = SYNC;
          tx_valid_d = 1'b1;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (count_d != '0) begin
              tx_data_d = SYNC;
            end else begin
              state_d    = IDLE;
              tx_valid_d = 1'b0;
            end
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = frame_byte(head, idx_q + 4'd1);
          end
        end
      end
    endcase
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_trace_tx.sv
// Scoreboard bench for trace_tx: directed captures push expected bytes; a
// negedge monitor compares every transferred byte and the handshake rules.
module tb_trace_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cap_en = 1'b0;
  logic [31:0] readDataMem = '0, ALUa = '0, ALUb = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        overflow;
  logic [3:0]  fifo_count;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  trace_tx #(.DEPTH(8), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en),
    .readDataMem(readDataMem), .ALUa(ALUa), .ALUb(ALUb),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] rd, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(a[8*i +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(b[8*i +: 8]);
  endtask

  task automatic capture(input logic [31:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_kept);
    cap_en = 1'b1; readDataMem = rd; ALUa = a; ALUb = b;
    if (expect_kept) push_frame(rd, a, b);
    tick();
    cap_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
    check("drain_count_zero", 32'(fifo_count), 32'd0);
  endtask

  // Monitor: compares transferred bytes against the scoreboard and checks
  // stall stability and that tx_valid stays high through a frame.
  int         byte_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst) begin
      byte_cnt   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(tx_valid), 32'd1);
        check("stall_data_held", 32'(tx_data), 32'(prev_data));
      end
      if (byte_cnt != 0) check("valid_mid_frame", 32'(tx_valid), 32'd1);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
        end else begin
          check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        byte_cnt = (byte_cnt + 1) % 13;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] frame1 [13] = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB,
                                8'hCD, 8'hEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    #3;
    check("reset_valid", 32'(tx_valid), 32'd0);
    check("reset_data", 32'(tx_data), 32'h00);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Single frame, hand-written byte list, exact latency and 13-cycle length.
    tx_ready = 1'b1;
    cap_en = 1'b1; readDataMem = 32'h01234567; ALUa = 32'h89ABCDEF; ALUb = 32'hDEADBEEF;
    foreach (frame1[i]) exp_q.push_back(frame1[i]);
    tick();
    cap_en = 1'b0;
    check("single_valid_at_capture", 32'(tx_valid), 32'd0);
    check("single_count_one", 32'(fifo_count), 32'd1);
    tick();
    check("single_latency_valid", 32'(tx_valid), 32'd1);
    check("single_latency_sync", 32'(tx_data), 32'hA5);
    repeat (13) tick();
    check("single_end_valid", 32'(tx_valid), 32'd0);
    check("single_end_count", 32'(fifo_count), 32'd0);
    check("single_all_bytes", 32'(exp_q.size()), 32'd0);

    // Backpressure with random ready.
    capture(32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 1'b1);
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
      tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    tx_ready = 1'b1;
    wait_drain(20);

    // Back-to-back frames: 39 bytes with no gap.
    capture(32'd1, 32'd1, 32'd1, 1'b1);
    capture(32'd2, 32'd2, 32'd2, 1'b1);
    capture(32'd3, 32'd3, 32'd3, 1'b1);
    check("b2b_count_peak", 32'(fifo_count), 32'd3);
    repeat (38) tick();
    check("b2b_end_valid", 32'(tx_valid), 32'd0);
    check("b2b_no_gap", 32'(exp_q.size()), 32'd0);

    // Overflow: 9 captures into 8 entries while stalled.
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      capture(32'h1000_0000 + i, 32'h2000_0000 + i, 32'h3000_0000 + i, i < 8);
    check("ovf_count_full", 32'(fifo_count), 32'd8);
    check("ovf_flag_set", 32'(overflow), 32'd1);
    tx_ready = 1'b1;
    wait_drain(8 * 13 + 20);
    check("ovf_flag_sticky", 32'(overflow), 32'd1);

    // Full FIFO with push on the edge of the last byte's transfer.
    do_reset();
    check("reset_clears_overflow", 32'(overflow), 32'd0);
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      capture(32'hA000_0000 + i, 32'hB000_0000 + i, 32'hC000_0000 + i, 1'b1);
    tx_ready = 1'b1;
    repeat (12) tick();
    capture(32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    check("pushpop_count", 32'(fifo_count), 32'd8);
    check("pushpop_no_overflow", 32'(overflow), 32'd0);
    wait_drain(9 * 13 + 20);

    // Asynchronous reset mid-frame with two entries queued.
    capture(32'h5555_0001, 32'h6666_0001, 32'h7777_0001, 1'b1);
    capture(32'h5555_0002, 32'h6666_0002, 32'h7777_0002, 1'b1);
    repeat (6) tick();
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_valid", 32'(tx_valid), 32'd0);
    check("async_reset_count", 32'(fifo_count), 32'd0);
    check("async_reset_data", 32'(tx_data), 32'h00);
    tick();
    tick();
    rst = 1'b1;
    repeat (20) tick();
    check("post_reset_silent", 32'(tx_valid), 32'd0);
    capture(32'hCAFE_BABE, 32'h0000_FFFF, 32'hFFFF_0000, 1'b1);
    tick();
    check("post_reset_sync", 32'(tx_data), 32'hA5);
    wait_drain(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
